// File: rtl/tl_pkg.sv
// Shared constants for the traffic-light controller: state encodings and
// light codes, used by the state sequencer and the output-encoding block.
package tl_pkg;

  // State encoding driven on Q2..Q0; all eight codes are live states.
  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A left
    S3 = 3'b011,  // A yellow
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B left
    S7 = 3'b111   // B yellow
  } tl_state_t;

  // Light codes produced downstream for La and Lb.
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

endpackage

// File: rtl/tl_dwell_cnt.sv
// Dwell timer for the traffic-light sequencer: counts cycles spent in the
// current state, clears synchronously on a state change and saturates at
// its all-ones value instead of wrapping.
module tl_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_resetN,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear on a state change, otherwise count up and hold at the top value.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != {CNT_W{1'b1}}) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tl_state_seq.sv
// Traffic-light state sequencer: 3-bit state register walking the fixed
// cycle S0..S7 under control of the dwell timer and the Ta/Tb sensors.
// Optional macro TL_LEFT_SKIP_EN adds La_req/Lb_req, which let the
// sequence bypass a left-turn state when no left turn is requested.
module tl_state_seq
  import tl_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_CYC = 2,
  parameter int LEFT_CYC   = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic Ta,
  input  logic Tb,
`ifdef TL_LEFT_SKIP_EN
  input  logic La_req,
  input  logic Lb_req,
`endif
  output logic Q2,
  output logic Q1,
  output logic Q0,
  output logic state_chg
);

  // Last counter values of each dwell, widened so they compare safely
  // against narrow counters.
  localparam logic [31:0] LP_GREEN_MIN_LAST = 32'(GREEN_MIN - 1);
  localparam logic [31:0] LP_GREEN_MAX_LAST = 32'(GREEN_MAX - 1);
  localparam logic [31:0] LP_YELLOW_LAST    = 32'(YELLOW_CYC - 1);
  localparam logic [31:0] LP_LEFT_LAST      = 32'(LEFT_CYC - 1);

  tl_state_t        r_state;
  logic             r_stateChg;
  tl_state_t        w_nextState;
  logic             w_leave;
  logic [CNT_W-1:0] w_cnt;
  logic [31:0]      w_cntWide;
  logic             w_greenMinMet;
  logic             w_greenMaxMet;

  tl_dwell_cnt #(
    .CNT_W(CNT_W)
  ) u_dwellCnt (
    .i_clk   (clk),
    .i_resetN(reset_n),
    .i_clear (w_leave),
    .o_count (w_cnt)
  );

  assign w_cntWide     = 32'(w_cnt);
  assign w_greenMinMet = (w_cntWide >= LP_GREEN_MIN_LAST);
  assign w_greenMaxMet = (w_cntWide >= LP_GREEN_MAX_LAST);

  // Decide whether the current state's dwell is over and where to go next.
  always_comb begin
    w_leave     = 1'b0;
    w_nextState = r_state;
    case (r_state)
      S0:             w_leave = Tb && w_greenMinMet && (!Ta || w_greenMaxMet);
      S4:             w_leave = w_greenMinMet && (!Tb || w_greenMaxMet);
      S1, S3, S5, S7: w_leave = (w_cntWide == LP_YELLOW_LAST);
      S2, S6:         w_leave = (w_cntWide == LP_LEFT_LAST);
      default:        w_leave = 1'b0;
    endcase
    if (w_leave) begin
      w_nextState = tl_state_t'(r_state + 3'd1);
`ifdef TL_LEFT_SKIP_EN
      if ((r_state == S1) && !La_req) begin
        w_nextState = S4;
      end
      if ((r_state == S5) && !Lb_req) begin
        w_nextState = S0;
      end
`endif
    end
  end

  // State register plus a pulse marking the first cycle of each new state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S0;
      r_stateChg <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_stateChg <= w_leave;
    end
  end

  assign Q2        = r_state[2];
  assign Q1        = r_state[1];
  assign Q0        = r_state[0];
  assign state_chg = r_stateChg;

endmodule

// File: tb/tb_tl_state_seq.sv
// Testbench for tl_state_seq: table-driven dwell sequences, hand-written
// reset/sensor corner cases, a narrow-counter instance, and a randomized
// run against a cycle-level reference model. Honours TL_LEFT_SKIP_EN.
module tb_tl_state_seq;
  import tl_pkg::*;

  localparam int GREEN_MIN  = 4;
  localparam int GREEN_MAX  = 16;
  localparam int YELLOW_CYC = 2;
  localparam int LEFT_CYC   = 3;

  typedef struct {
    logic       ta;
    logic       tb;
    logic [2:0] st;
    int         len;
    logic       chgFirst;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ta = 1'b0;
  logic tb = 1'b0;
  logic ta3 = 1'b0;
  logic tb3 = 1'b0;
  logic q2, q1, q0, stateChg;
  logic q2s, q1s, q0s, stateChgS;
`ifdef TL_LEFT_SKIP_EN
  logic laReq = 1'b1;
  logic lbReq = 1'b1;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference model: state number and cycles already spent in it.
  int   mState = 0;
  int   mDwell = 0;
  logic mChg = 1'b0;

  vec_t vecs[16];

  always #5 clk = ~clk;

  tl_state_seq #(
    .CNT_W(8), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_CYC(YELLOW_CYC), .LEFT_CYC(LEFT_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .Ta(ta), .Tb(tb),
`ifdef TL_LEFT_SKIP_EN
    .La_req(laReq), .Lb_req(lbReq),
`endif
    .Q2(q2), .Q1(q1), .Q0(q0), .state_chg(stateChg)
  );

  tl_state_seq #(
    .CNT_W(3), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_CYC(YELLOW_CYC), .LEFT_CYC(LEFT_CYC)
  ) dutNarrow (
    .clk(clk), .reset_n(reset_n), .Ta(ta3), .Tb(tb3),
`ifdef TL_LEFT_SKIP_EN
    .La_req(1'b1), .Lb_req(1'b1),
`endif
    .Q2(q2s), .Q1(q1s), .Q0(q0s), .state_chg(stateChgS)
  );

  task automatic modelReset();
    mState = 0;
    mDwell = 0;
    mChg   = 1'b0;
  endtask

  // One clock of the traffic rules, using plain integers.
  task automatic modelAdvance(input logic a, input logic b, input logic la, input logic lb);
    bit leave;
    int dwellMax;
    dwellMax = 255;
    if (mState == 0)
      leave = b && (mDwell + 1 >= GREEN_MIN) && (!a || mDwell + 1 >= GREEN_MAX);
    else if (mState == 4)
      leave = (mDwell + 1 >= GREEN_MIN) && (!b || mDwell + 1 >= GREEN_MAX);
    else if (mState == 2 || mState == 6)
      leave = (mDwell + 1 == LEFT_CYC);
    else
      leave = (mDwell + 1 == YELLOW_CYC);
    if (leave) begin
      if (mState == 1 && !la) mState = 4;
      else if (mState == 5 && !lb) mState = 0;
      else mState = (mState + 1) % 8;
      mDwell = 0;
      mChg   = 1'b1;
    end else begin
      mDwell = (mDwell < dwellMax) ? mDwell + 1 : dwellMax;
      mChg   = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b);
    ta = a;
    tb = b;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] actQ, input logic actChg,
                             input logic [2:0] expQ, input logic expChg);
    compared++;
    if (actQ !== expQ || actChg !== expChg) begin
      mismatched++;
      $display("[TB] FAIL %s: got Q=%b chg=%b, expected Q=%b chg=%b",
               name, actQ, actChg, expQ, expChg);
    end
  endtask

  // Advance one clock, keep the model in step, and settle past the edge.
  task automatic stepCycle();
    logic la, lb;
    la = 1'b1;
    lb = 1'b1;
    @(posedge clk);
`ifdef TL_LEFT_SKIP_EN
    la = laReq;
    lb = lbReq;
`endif
    if (!reset_n) modelReset();
    else modelAdvance(ta, tb, la, lb);
    #1;
  endtask

  task automatic runState(input string name, input logic a, input logic b,
                          input logic [2:0] st, input int len, input logic chgFirst);
    applyStimulus(a, b);
    for (int k = 0; k < len; k++) begin
      checkOutput(name, {q2, q1, q0}, stateChg, st, (k == 0) ? chgFirst : 1'b0);
      stepCycle();
    end
  endtask

  initial begin
    // Fixed cycle with Ta=0/Tb=1 (B released once it is served), then both busy.
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 4,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 2,  1'b1};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 3,  1'b1};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 2,  1'b1};
    vecs[4]  = '{1'b0, 1'b0, 3'd4, 4,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 3'd5, 2,  1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'd6, 3,  1'b1};
    vecs[7]  = '{1'b0, 1'b0, 3'd7, 2,  1'b1};
    vecs[8]  = '{1'b1, 1'b1, 3'd0, 16, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 3'd1, 2,  1'b1};
    vecs[10] = '{1'b1, 1'b1, 3'd2, 3,  1'b1};
    vecs[11] = '{1'b1, 1'b1, 3'd3, 2,  1'b1};
    vecs[12] = '{1'b1, 1'b1, 3'd4, 16, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 3'd5, 2,  1'b1};
    vecs[14] = '{1'b1, 1'b1, 3'd6, 3,  1'b1};
    vecs[15] = '{1'b1, 1'b1, 3'd7, 2,  1'b1};

    // Power-on reset.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", {q2, q1, q0}, stateChg, 3'd0, 1'b0);
    checkOutput("resetNarrow", {q2s, q1s, q0s}, stateChgS, 3'd0, 1'b0);
    modelReset();
    reset_n = 1'b1;

    // Table of full dwell sequences.
    for (int i = 0; i < 16; i++) begin
      runState($sformatf("vec%0d", i), vecs[i].ta, vecs[i].tb, vecs[i].st,
               vecs[i].len, vecs[i].chgFirst);
    end
    checkOutput("wrapToS0", {q2, q1, q0}, stateChg, 3'd0, 1'b1);

    // B green held by traffic for 6 cycles, released on the 7th.
    runState("t4S0", 1'b0, 1'b1, 3'd0, 4, 1'b1);
    runState("t4S1", 1'b0, 1'b1, 3'd1, 2, 1'b1);
    runState("t4S2", 1'b0, 1'b1, 3'd2, 3, 1'b1);
    runState("t4S3", 1'b0, 1'b1, 3'd3, 2, 1'b1);
    runState("t4S4busy", 1'b0, 1'b1, 3'd4, 6, 1'b1);
    runState("t4S4idle", 1'b0, 1'b0, 3'd4, 1, 1'b0);
    checkOutput("s4TbDrop", {q2, q1, q0}, stateChg, 3'd5, 1'b1);

    // Walk into S2 and assert reset between edges.
    runState("t1S5", 1'b0, 1'b1, 3'd5, 2, 1'b1);
    runState("t1S6", 1'b0, 1'b1, 3'd6, 3, 1'b1);
    runState("t1S7", 1'b0, 1'b1, 3'd7, 2, 1'b1);
    runState("t1S0", 1'b0, 1'b1, 3'd0, 4, 1'b1);
    runState("t1S1", 1'b0, 1'b1, 3'd1, 2, 1'b1);
    runState("t1S2", 1'b0, 1'b1, 3'd2, 1, 1'b1);
    checkOutput("midS2", {q2, q1, q0}, stateChg, 3'd2, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncReset", {q2, q1, q0}, stateChg, 3'd0, 1'b0);
    modelReset();
    stepCycle();
    applyStimulus(1'($urandom_range(0, 1)), 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checkOutput("restOnA", {q2, q1, q0}, stateChg, 3'd0, 1'b0);
      stepCycle();
    end

`ifdef TL_LEFT_SKIP_EN
    // Left-turn skip on A, left turn taken on B.
    applyStimulus(1'b0, 1'b1);
    checkOutput("skipS0", {q2, q1, q0}, stateChg, 3'd0, 1'b0);
    stepCycle();
    laReq = 1'b0;
    checkOutput("skipS1a", {q2, q1, q0}, stateChg, 3'd1, 1'b1);
    stepCycle();
    checkOutput("skipS1b", {q2, q1, q0}, stateChg, 3'd1, 1'b0);
    stepCycle();
    laReq = 1'b1;
    runState("skipS4", 1'b0, 1'b0, 3'd4, 4, 1'b1);
    runState("skipS5", 1'b0, 1'b0, 3'd5, 2, 1'b1);
    checkOutput("takeS6", {q2, q1, q0}, stateChg, 3'd6, 1'b1);
`endif

    // Randomized run against the reference model.
    reset_n = 1'b0;
    stepCycle();
    reset_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) ta = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) tb = 1'($urandom_range(0, 1));
`ifdef TL_LEFT_SKIP_EN
      laReq = 1'($urandom_range(0, 1));
      lbReq = 1'($urandom_range(0, 1));
`endif
      if (i == 700) begin
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("randReset", {q2, q1, q0}, stateChg, 3'd0, 1'b0);
        stepCycle();
        reset_n = 1'b1;
      end
      checkOutput("random", {q2, q1, q0}, stateChg, 3'(mState), mChg);
      stepCycle();
    end
`ifdef TL_LEFT_SKIP_EN
    laReq = 1'b1;
    lbReq = 1'b1;
`endif

    // Narrow counter: A busy, B idle; the counter must stick at 7, not wrap.
    reset_n = 1'b0;
    stepCycle();
    reset_n = 1'b1;
    ta3 = 1'b1;
    tb3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      checkOutput("narrowRest", {q2s, q1s, q0s}, stateChgS, 3'd0, 1'b0);
      stepCycle();
    end
    ta3 = 1'b0;
    tb3 = 1'b1;
    checkOutput("narrowHold", {q2s, q1s, q0s}, stateChgS, 3'd0, 1'b0);
    stepCycle();
    checkOutput("narrowSat", {q2s, q1s, q0s}, stateChgS, 3'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
